// File: rtl/eth_idma_reg_frontend.sv
// Register-bus target for the Ethernet iDMA wrapper: MAC address/config, iDMA launch and status.
// Each access takes 2 cycles (decode, then one-cycle reg_ready_o); ETH_IDMA_REG_XFER_CNT_EN adds a completion counter at 0x48.
module eth_idma_reg_frontend #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned TFLenWidth   = 32,
  parameter int unsigned OutstWidth   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [RegAddrWidth-1:0] reg_addr_i,
  input  logic [31:0]             reg_wdata_i,
  input  logic [3:0]              reg_wstrb_i,
  output logic [31:0]             reg_rdata_o,
  output logic                    reg_ready_o,
  output logic                    reg_error_o,
  output logic [47:0]             mac_addr_o,
  output logic [15:0]             mac_cfg_o,
  output logic                    idma_req_valid_o,
  input  logic                    idma_req_ready_i,
  output logic [AddrWidth-1:0]    src_addr_o,
  output logic [AddrWidth-1:0]    dst_addr_o,
  output logic [TFLenWidth-1:0]   length_o,
  output logic [2:0]              src_protocol_o,
  output logic [2:0]              dst_protocol_o,
  input  logic                    idma_rsp_valid_i,
  output logic                    idma_rsp_ready_o,
  input  logic                    idma_rsp_error_i,
  output logic                    busy_o
);
  typedef enum logic {IDLE, RESP} state_e;
  localparam logic [OutstWidth-1:0] OutstMax = '1;

  state_e                state_q, state_d;
  logic [47:0]           mac_q;
  logic [15:0]           cfg_q;
  logic [31:0]           src_q, dst_q;
  logic [TFLenWidth-1:0] len_q;
  logic [2:0]            sproto_q, dproto_q;
  logic                  req_valid_q, rsp_ready_q, done_q, err_q, busy_q;
  logic [OutstWidth-1:0] outst_q, outst_d;
  logic [31:0]           rdata_q, rdata_d, cur, merged, status;
  logic                  error_q, error_d;
  logic                  acc, wr, locked, req_hs, rsp_hs;
  logic [1:0]            w1c;
  logic                  we_mac0, we_mac1, we_src, we_dst, we_len, we_sproto, we_dproto;
  logic                  we_reqv, we_rspr, we_stat;
  logic                  unused_addr_bits;
`ifdef ETH_IDMA_REG_XFER_CNT_EN
  logic [31:0]           cnt_q;
  logic                  we_cnt;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
    return res;
  endfunction

  assign acc    = (state_q == IDLE) && reg_valid_i;
  assign wr     = acc && reg_write_i;
  assign locked = idma_req_valid_o;
  assign req_hs = idma_req_valid_o && idma_req_ready_i;
  assign rsp_hs = idma_rsp_valid_i && rsp_ready_q;
  assign status = {24'h0, 4'(outst_q), 1'b0, busy_q, err_q, done_q};
  assign w1c    = (we_stat && reg_wstrb_i[0]) ? reg_wdata_i[1:0] : 2'b00;
  assign unused_addr_bits = ^reg_addr_i[RegAddrWidth-1:8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reg_valid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_ready_o = (state_q == RESP);
  end

  // cur is the readback of the addressed register; writes merge strobed bytes into it
  always_comb begin
    cur       = '0;
    error_d   = 1'b0;
    we_mac0   = 1'b0;
    we_mac1   = 1'b0;
    we_src    = 1'b0;
    we_dst    = 1'b0;
    we_len    = 1'b0;
    we_sproto = 1'b0;
    we_dproto = 1'b0;
    we_reqv   = 1'b0;
    we_rspr   = 1'b0;
    we_stat   = 1'b0;
`ifdef ETH_IDMA_REG_XFER_CNT_EN
    we_cnt    = 1'b0;
`endif
    case (reg_addr_i[7:0])
      8'h00: begin cur = mac_q[31:0];              we_mac0 = wr; end
      8'h04: begin cur = {cfg_q, mac_q[47:32]};    we_mac1 = wr; end
      8'h10: begin cur = src_q;            we_src    = wr && !locked; error_d = reg_write_i && locked; end
      8'h14: begin cur = dst_q;            we_dst    = wr && !locked; error_d = reg_write_i && locked; end
      8'h18: begin cur = 32'(len_q);       we_len    = wr && !locked; error_d = reg_write_i && locked; end
      8'h1C: begin cur = {29'h0, sproto_q}; we_sproto = wr && !locked; error_d = reg_write_i && locked; end
      8'h20: begin cur = {29'h0, dproto_q}; we_dproto = wr && !locked; error_d = reg_write_i && locked; end
      8'h38: begin cur = {31'h0, req_valid_q};      we_reqv = wr; end
      8'h3C: begin cur = {31'h0, idma_req_ready_i}; error_d = reg_write_i; end
      8'h40: begin cur = {31'h0, rsp_ready_q};      we_rspr = wr; end
      8'h44: begin cur = status;                    we_stat = wr; end
`ifdef ETH_IDMA_REG_XFER_CNT_EN
      8'h48: begin cur = cnt_q;                     we_cnt  = wr; end
`endif
      default: error_d = 1'b1;
    endcase
    rdata_d = (reg_write_i || error_d) ? 32'h0 : cur;
    merged  = merge(cur, reg_wdata_i, reg_wstrb_i);
  end

  // A response racing a request leaves the count alone; a response at zero never underflows
  always_comb begin
    outst_d = outst_q;
    if (req_hs && !rsp_hs)                          outst_d = outst_q + OutstWidth'(1);
    else if (rsp_hs && !req_hs && outst_q != '0)    outst_d = outst_q - OutstWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q     <= '0;
      error_q     <= 1'b0;
      mac_q       <= '0;
      cfg_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      sproto_q    <= '0;
      dproto_q    <= '0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (acc) begin
        rdata_q <= rdata_d;
        error_q <= error_d;
      end
      if (we_mac0)   mac_q[31:0]            <= merged;
      if (we_mac1)   {cfg_q, mac_q[47:32]}  <= merged;
      if (we_src)    src_q                  <= merged;
      if (we_dst)    dst_q                  <= merged;
      if (we_len)    len_q                  <= merged[TFLenWidth-1:0];
      if (we_sproto) sproto_q               <= merged[2:0];
      if (we_dproto) dproto_q               <= merged[2:0];
      if (we_rspr)   rsp_ready_q            <= merged[0];
      if (we_reqv && reg_wstrb_i[0]) req_valid_q <= reg_wdata_i[0];
      else if (req_hs)               req_valid_q <= 1'b0;
      done_q  <= (done_q & ~w1c[0]) | rsp_hs;
      err_q   <= (err_q & ~w1c[1]) | (rsp_hs & (idma_rsp_error_i | (outst_q == '0)));
      outst_q <= outst_d;
      busy_q  <= (outst_d != '0);
    end
  end

`ifdef ETH_IDMA_REG_XFER_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (we_cnt) cnt_q <= {31'h0, rsp_hs};
    else if (rsp_hs) cnt_q <= cnt_q + 32'd1;
  end
`endif

  assign reg_rdata_o      = rdata_q;
  assign reg_error_o      = error_q;
  assign mac_addr_o       = mac_q;
  assign mac_cfg_o        = cfg_q;
  assign idma_req_valid_o = req_valid_q && (outst_q != OutstMax);
  assign src_addr_o       = AddrWidth'(src_q);
  assign dst_addr_o       = AddrWidth'(dst_q);
  assign length_o         = len_q;
  assign src_protocol_o   = sproto_q;
  assign dst_protocol_o   = dproto_q;
  assign idma_rsp_ready_o = rsp_ready_q;
  assign busy_o           = busy_q;
endmodule
